ibr128_block_engine: RTL and testbench
======================================

// Module: ibr128_block_engine
// PURPOSE
// - Responder side of the 128-bit block handshake (block_start/pData/encrypt/sa -> block_ready/eData).
// - Driven by the IBR128 operation-mode controller; runs an iterative 64/64 Feistel core, one round per cycle.
// - Encrypt and decrypt share one datapath; decrypt walks the round keys in reverse order.
// PARAMETERS
// - NROUNDS  16  Feistel rounds per block; 1..63; must be even when IBR128_ENGINE_UNROLL2_EN is set.
// PORTS
// - Clk          in   1    clock, rising edge.
// - RstN         in   1    reset, asynchronous, active-low.
// - Enable       in   1    0 = synchronous abort: state to IDLE, outputs to reset values.
// - block_start  in   1    request level; sampled only in IDLE.
// - encrypt      in   1    1 = encrypt, 0 = decrypt; latched at capture.
// - pData        in   128  input block {L[127:64], R[63:0]}; latched at capture.
// - sa           in   1    1 = keep the previously latched keys; 0 = latch key0/key1 at capture.
// - key0         in   64   even-round key.
// - key1         in   64   odd-round key.
// - block_ready  out  1    one-cycle completion pulse.
// - eData        out  128  result; held until the next completion.
// - busy         out  1    high from the capture edge until the block_ready cycle, inclusive.
// BEHAVIOUR
// - Reset (RstN=0, async) or Enable=0 (sync): state=IDLE, block_ready=0, eData=0, busy=0, round=0, latched keys=0.
// - FSM states: IDLE, RUN, COOL.
//   - IDLE->RUN on block_start=1 (capture edge E0): latch L, R, dir, keys per sa; round=0; busy=1.
//   - RUN: each edge applies one round, round+=1. At the final round's edge: eData={R',L'}, block_ready=1, ->COOL.
//   - COOL: lasts 2 cycles with block_ready=0, busy=0, then ->IDLE.
//     The 2 cycles let the controller register eData and present its next pData.
// - Latency: block_ready is high in the cycle after edge E0+NROUNDS.
//   Back-to-back throughput: one block per NROUNDS+3 cycles while block_start is held high.
// - Round i, encrypt: K = (i even) ? k0 : k1.
//   Round i, decrypt: K chosen by the parity of NROUNDS-1-i (reverse order).
// - Round update: L' = R; R' = L ^ F(R,K).
//   F(R,K) = ((R ^ K) rotl 7) + K, mod 2^64 (64-bit wrap, no carry out).
// - Output swap: eData = {R_N, L_N}. Decrypting that value with the same keys returns the original pData.
// - Boundaries:
//   - block_start dropping during RUN or COOL: ignored; the block completes.
//   - pData, key or encrypt changes after capture: no effect on the block in flight.
//   - sa=1 on the first block after reset: uses the reset keys (0).
//   - Enable falling mid-RUN: block discarded; no block_ready pulse.
//   - NROUNDS=1: block_ready is high in the cycle after edge E0+1.
// CONFIGURATION
// - IBR128_ENGINE_UNROLL2_EN defined:
//   - Two cascaded rounds per RUN cycle; latency NROUNDS/2.
//   - Key parity is computed per half-round; results are bit-identical to the 1-round build.
// - Not defined: one round per cycle as above.
// STRUCTURE
// - Shared package ibr128_pkg:
//   - typedef enum {IDLE,RUN,COOL} eng_state_t
//   - localparam ROT_F=7
//   - function ibr128_f(R,K)
// - Sub-module ibr128_round: combinational single Feistel round (L,R,K -> L',R').
//   Instantiated once, or twice under IBR128_ENGINE_UNROLL2_EN.
// TESTING
// - Zero vector: NROUNDS=16, pData=0, keys=0, encrypt=1 -> eData=0; block_ready high in the cycle after edge E0+16.
// - Hand-checkable round: NROUNDS=1, pData={64'h1,64'h0}, keys=0 -> eData=128'h0000000000000001_0000000000000000.
// - Round trip:
//   - pData=128'h0123456789ABCDEF_FEDCBA9876543210, key0=64'hA5A5A5A5A5A5A5A5, key1=64'h0F0F0F0F0F0F0F0F.
//   - Encrypt, then decrypt the resulting eData -> original pData.
// - Streaming: block_start held high for 3 blocks -> block_ready pulses exactly NROUNDS+3 cycles apart.
//   Each block uses the pData present 2 cycles after the previous pulse.
// - Abort: Enable=0 at round 5 -> no block_ready, eData=0, busy=0.
//   Next block after Enable=1 produces correct results.
// - sa=1 with key0/key1 changed after the first block -> eData matches the first block's keys.
//   Repeat both of the above with IBR128_ENGINE_UNROLL2_EN defined; latency must halve.

Source files
------------

// File: rtl/ibr128_pkg.sv
// Shared state type, rotation constant and Feistel round function for the IBR128 block engine.
package ibr128_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      COOL = 2'd2
   } eng_state_t;

   localparam int ROT_F = 7;

   // F(R,K) = ((R ^ K) rotl ROT_F) + K, wrapping at 64 bits.
   function automatic logic [63:0] ibr128_f(input logic [63:0] r, input logic [63:0] k);
      logic [63:0] x;
      x = r ^ k;
      return ((x << ROT_F) | (x >> (64 - ROT_F))) + k;
   endfunction

endpackage

// File: rtl/ibr128_round.sv
// One combinational Feistel round: L' = R, R' = L ^ F(R,K).
module ibr128_round
   import ibr128_pkg::*;
(
   input  logic [63:0] l_i,
   input  logic [63:0] r_i,
   input  logic [63:0] k_i,
   output logic [63:0] l_o,
   output logic [63:0] r_o
);

   assign l_o = r_i;
   assign r_o = l_i ^ ibr128_f(r_i, k_i);

endmodule

// File: rtl/ibr128_block_engine.sv
// Iterative 64/64 Feistel block engine answering the IBR128 block_start/block_ready handshake.
// Define IBR128_ENGINE_UNROLL2_EN to apply two rounds per RUN cycle (NROUNDS must then be even).
module ibr128_block_engine
   import ibr128_pkg::*;
#(
   parameter int NROUNDS = 16
)
(
   input  logic         Clk,
   input  logic         RstN,
   input  logic         Enable,
   input  logic         block_start,
   input  logic         encrypt,
   input  logic [127:0] pData,
   input  logic         sa,
   input  logic [63:0]  key0,
   input  logic [63:0]  key1,
   output logic         block_ready,
   output logic [127:0] eData,
   output logic         busy
);

   // Decrypt uses the parity of NROUNDS-1-i, i.e. round parity flipped when NROUNDS-1 is odd.
   localparam logic REV_PAR = (((NROUNDS - 1) % 2) == 1) ? 1'b1 : 1'b0;

`ifdef IBR128_ENGINE_UNROLL2_EN
   localparam logic [5:0] STEP       = 6'd2;
   localparam logic [5:0] LAST_ROUND = 6'(NROUNDS - 2);
`else
   localparam logic [5:0] STEP       = 6'd1;
   localparam logic [5:0] LAST_ROUND = 6'(NROUNDS - 1);
`endif

   eng_state_t   state_q;
   logic [5:0]   round_q;
   logic         cool_q;
   logic         enc_q;
   logic [63:0]  l_q, r_q, k0_q, k1_q;
   logic         block_ready_q;
   logic [127:0] edata_q;
   logic         busy_q;

   logic [63:0]  ka, l_a, r_a;
   logic [63:0]  l_d, r_d;

   function automatic logic [63:0] round_key(input logic idx0, input logic enc,
                                             input logic [63:0] k0, input logic [63:0] k1);
      logic odd;
      odd = enc ? idx0 : (idx0 ^ REV_PAR);
      return odd ? k1 : k0;
   endfunction

   assign ka = round_key(round_q[0], enc_q, k0_q, k1_q);

   ibr128_round u_round_a (
      .l_i (l_q),
      .r_i (r_q),
      .k_i (ka),
      .l_o (l_a),
      .r_o (r_a)
   );

`ifdef IBR128_ENGINE_UNROLL2_EN
   logic [63:0] kb;

   // Second half-round always has the opposite round-index parity of the first.
   assign kb = round_key(~round_q[0], enc_q, k0_q, k1_q);

   ibr128_round u_round_b (
      .l_i (l_a),
      .r_i (r_a),
      .k_i (kb),
      .l_o (l_d),
      .r_o (r_d)
   );
`else
   assign l_d = l_a;
   assign r_d = r_a;
`endif

   // Handshake FSM, round datapath and registered outputs.
   always_ff @(posedge Clk or negedge RstN) begin
      if (!RstN) begin
         state_q       <= IDLE;
         round_q       <= 6'd0;
         cool_q        <= 1'b0;
         enc_q         <= 1'b0;
         l_q           <= 64'd0;
         r_q           <= 64'd0;
         k0_q          <= 64'd0;
         k1_q          <= 64'd0;
         block_ready_q <= 1'b0;
         edata_q       <= 128'd0;
         busy_q        <= 1'b0;
      end else if (!Enable) begin
         state_q       <= IDLE;
         round_q       <= 6'd0;
         cool_q        <= 1'b0;
         enc_q         <= 1'b0;
         l_q           <= 64'd0;
         r_q           <= 64'd0;
         k0_q          <= 64'd0;
         k1_q          <= 64'd0;
         block_ready_q <= 1'b0;
         edata_q       <= 128'd0;
         busy_q        <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               block_ready_q <= 1'b0;
               if (block_start) begin
                  l_q     <= pData[127:64];
                  r_q     <= pData[63:0];
                  enc_q   <= encrypt;
                  round_q <= 6'd0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
                  if (!sa) begin
                     k0_q <= key0;
                     k1_q <= key1;
                  end
               end
            end
            RUN: begin
               l_q     <= l_d;
               r_q     <= r_d;
               round_q <= round_q + STEP;
               if (round_q == LAST_ROUND) begin
                  // Output carries the final swap so that decrypt is the same datapath.
                  edata_q       <= {r_d, l_d};
                  block_ready_q <= 1'b1;
                  round_q       <= 6'd0;
                  cool_q        <= 1'b0;
                  state_q       <= COOL;
               end
            end
            COOL: begin
               block_ready_q <= 1'b0;
               busy_q        <= 1'b0;
               cool_q        <= 1'b1;
               if (cool_q) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q       <= IDLE;
               block_ready_q <= 1'b0;
               busy_q        <= 1'b0;
            end
         endcase
      end
   end

   assign block_ready = block_ready_q;
   assign eData       = edata_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_ibr128_block_engine.sv
// Directed self-checking bench for ibr128_block_engine (16-round and minimal-round instances).
module tb_ibr128_block_engine;

`ifdef IBR128_ENGINE_UNROLL2_EN
   localparam int NR_BIG = 16;
   localparam int LAT_BIG = 8;
   localparam int NR_SMALL = 2;
   localparam int LAT_SMALL = 1;
   localparam logic [127:0] EXP_SMALL = 128'h0000000000000080_0000000000000001;
`else
   localparam int NR_BIG = 16;
   localparam int LAT_BIG = 16;
   localparam int NR_SMALL = 1;
   localparam int LAT_SMALL = 1;
   localparam logic [127:0] EXP_SMALL = 128'h0000000000000001_0000000000000000;
`endif

   localparam logic [127:0] RT_P = 128'h0123456789ABCDEF_FEDCBA9876543210;
   localparam logic [63:0]  KA   = 64'hA5A5A5A5A5A5A5A5;
   localparam logic [63:0]  KB   = 64'h0F0F0F0F0F0F0F0F;
   localparam logic [63:0]  KC   = 64'h1122334455667788;
   localparam logic [63:0]  KD   = 64'h99AABBCCDDEEFF00;
   localparam logic [127:0] JUNK = 128'hDEADBEEFDEADBEEF_CAFEF00DCAFEF00D;

   logic         Clk, RstN, Enable, encrypt, sa, bs16, bs1;
   logic [127:0] pData;
   logic [63:0]  key0, key1;
   logic         br16, busy16, br1, busy1;
   logic [127:0] ed16, ed1;

   int total = 0;
   int bad = 0;

   ibr128_block_engine #(.NROUNDS(NR_BIG)) dut16 (
      .Clk(Clk), .RstN(RstN), .Enable(Enable), .block_start(bs16), .encrypt(encrypt),
      .pData(pData), .sa(sa), .key0(key0), .key1(key1),
      .block_ready(br16), .eData(ed16), .busy(busy16)
   );

   ibr128_block_engine #(.NROUNDS(NR_SMALL)) dut1 (
      .Clk(Clk), .RstN(RstN), .Enable(Enable), .block_start(bs1), .encrypt(encrypt),
      .pData(pData), .sa(sa), .key0(key0), .key1(key1),
      .block_ready(br1), .eData(ed1), .busy(busy1)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Independent reference: plain Feistel loop, keys indexed directly per round.
   function automatic logic [127:0] ref_model(input logic [127:0] p, input logic [63:0] k0,
                                              input logic [63:0] k1, input int n, input logic enc);
      logic [63:0] l, r, t, k, x;
      l = p[127:64];
      r = p[63:0];
      for (int i = 0; i < n; i++) begin
         if (enc) k = ((i % 2) == 0) ? k0 : k1;
         else     k = (((n - 1 - i) % 2) == 0) ? k0 : k1;
         x = r ^ k;
         x = {x[56:0], x[63:57]};
         t = l ^ (x + k);
         l = r;
         r = t;
      end
      return {r, l};
   endfunction

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One block on the 16-round instance; inputs are scrambled right after capture.
   task automatic run_block(input string tag, input logic [127:0] p, input logic enc, input logic s,
                            input logic [63:0] a, input logic [63:0] b, input logic [127:0] exp);
      int  cyc;
      logic got;
      pData = p; encrypt = enc; sa = s; key0 = a; key1 = b; bs16 = 1'b1;
      step();
      bs16 = 1'b0; pData = ~p; encrypt = ~enc; key0 = ~a; key1 = ~b;
      check({tag, "_busy_capture"}, busy16, 1'b1);
      got = 1'b0;
      cyc = 0;
      while (!got && cyc < 200) begin
         step();
         cyc++;
         if (br16) got = 1'b1;
      end
      check({tag, "_latency"}, cyc, LAT_BIG);
      check({tag, "_edata"}, ed16, exp);
      check({tag, "_busy_ready"}, busy16, 1'b1);
      step();
      check({tag, "_pulse_width"}, br16, 1'b0);
      check({tag, "_busy_clear"}, busy16, 1'b0);
      check({tag, "_edata_hold"}, ed16, exp);
      step();
   endtask

   initial begin
      logic [127:0] ct, sp [3];
      int cyc, pulses, last;
      logic seen;

      RstN = 1'b0; Enable = 1'b1; encrypt = 1'b0; sa = 1'b0; bs16 = 1'b0; bs1 = 1'b0;
      pData = 128'd0; key0 = 64'd0; key1 = 64'd0;
      #3;
      check("reset_ready", br16, 1'b0);
      check("reset_edata", ed16, 128'd0);
      check("reset_busy", busy16, 1'b0);
      check("reset_edata_small", ed1, 128'd0);
      step(); step();
      RstN = 1'b1;
      step();

      // Zero vector; sa=1 here also exercises the reset keys.
      run_block("zero", 128'd0, 1'b1, 1'b1, KA, KB, 128'd0);

      // Minimal-round instance, hand-computed result.
      pData = {64'h1, 64'h0}; encrypt = 1'b1; sa = 1'b0; key0 = 64'd0; key1 = 64'd0; bs1 = 1'b1;
      step();
      bs1 = 1'b0; pData = JUNK;
      check("small_busy", busy1, 1'b1);
      cyc = 0;
      while (!br1 && cyc < 50) begin step(); cyc++; end
      check("small_latency", cyc, LAT_SMALL);
      check("small_edata", ed1, EXP_SMALL);
      step(); step(); step();

      // Round trip.
      ct = ref_model(RT_P, KA, KB, NR_BIG, 1'b1);
      run_block("enc", RT_P, 1'b1, 1'b0, KA, KB, ct);
      run_block("dec", ct, 1'b0, 1'b0, KA, KB, RT_P);
      run_block("dec_model", RT_P, 1'b0, 1'b0, KA, KB, ref_model(RT_P, KA, KB, NR_BIG, 1'b0));

      // sa=1 keeps the keys latched by the previous block.
      run_block("sa_first", JUNK, 1'b1, 1'b0, KC, KD, ref_model(JUNK, KC, KD, NR_BIG, 1'b1));
      run_block("sa_keep", RT_P, 1'b1, 1'b1, KA, KB, ref_model(RT_P, KC, KD, NR_BIG, 1'b1));

      // Abort mid-RUN.
      pData = RT_P; encrypt = 1'b1; sa = 1'b0; key0 = KA; key1 = KB; bs16 = 1'b1;
      step();
      bs16 = 1'b0;
      repeat (5) step();
      Enable = 1'b0;
      step();
      check("abort_ready", br16, 1'b0);
      check("abort_edata", ed16, 128'd0);
      check("abort_busy", busy16, 1'b0);
      Enable = 1'b1;
      seen = 1'b0;
      repeat (LAT_BIG + 6) begin
         step();
         if (br16 || busy16) seen = 1'b1;
      end
      check("abort_no_pulse", seen, 1'b0);
      run_block("post_abort_sa", RT_P, 1'b1, 1'b1, KA, KB, ref_model(RT_P, 64'd0, 64'd0, NR_BIG, 1'b1));
      run_block("post_abort", RT_P, 1'b1, 1'b0, KA, KB, ct);

      // Streaming with block_start held high.
      sp[0] = 128'h00000000000000FF_1234000000000001;
      sp[1] = RT_P;
      sp[2] = 128'h8000000000000000_7FFFFFFFFFFFFFFF;
      pData = sp[0]; encrypt = 1'b1; sa = 1'b0; key0 = KA; key1 = KB; bs16 = 1'b1;
      step();
      pData = JUNK;
      pulses = 0;
      last = 0;
      for (int c = 1; c <= 400 && pulses < 3; c++) begin
         step();
         if (br16) begin
            check("stream_edata", ed16, ref_model(sp[pulses], KA, KB, NR_BIG, 1'b1));
            if (pulses == 0) check("stream_first_latency", c, LAT_BIG);
            else             check("stream_spacing", c - last, LAT_BIG + 3);
            last = c;
            pulses++;
            if (pulses == 3) bs16 = 1'b0;
         end
         if (pulses > 0 && pulses < 3 && c == last + 2) pData = sp[pulses];
         else                                           pData = JUNK;
      end
      check("stream_count", pulses, 3);
      step(); step(); step();
      check("final_idle_busy", busy16, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
